// File: rtl/pxi_wr_regbank_if.sv
// PXI write-side bus: asynchronous write strobe plus the address/data it qualifies.
// The backplane model drives the master side and the register bank receives on the slave side.
interface pxi_wr_regbank_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              pxi_wr;
    logic [ADDR_W-1:0] pxi_addr;
    logic [DATA_W-1:0] pxi_data;

    modport master (output pxi_wr, output pxi_addr, output pxi_data);
    modport slave  (input  pxi_wr, input  pxi_addr, input  pxi_data);
endinterface

// File: rtl/pxi_wr_regbank.sv
// PXI write capture into a clk-domain register bank with per-register update pulses.
// Optional macro PXI_WR_FILTER_EN inserts a FILT_CYC-clock glitch filter after the strobe synchroniser.
//
// state    | meaning
// IDLE     | waiting for the synchronised strobe to go high; bus is latched on exit
// CAPT     | addr_r/data_r hold the latched bus; the commit edge ends this state
// COMMIT   | register bank already shows the new value; reg_upd is issued on exit
// WAIT_LOW | write done, waiting for the strobe to drop so one strobe gives one write
module pxi_wr_regbank #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 4,
    parameter int              NUM_REGS    = 12,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_CYC    = 3,
    parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pxi_wr_regbank_if.slave            pxi,
    input  logic                       err_clr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_upd,
    output logic                       busy,
    output logic                       err_addr,
    output logic [15:0]                wr_cnt
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("pxi_wr_regbank: SYNC_STAGES must be at least 2");
    end
    if (NUM_REGS > (1 << ADDR_W)) begin : g_chk_regs
        $error("pxi_wr_regbank: NUM_REGS exceeds the address space");
    end
    if (FILT_CYC < 1) begin : g_chk_filt
        $error("pxi_wr_regbank: FILT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPT     = 2'd1,
        COMMIT   = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              wr_s;
    logic              wr_f;
    logic              cap_en;
    logic              commit_en;
    logic              upd_en;
    logic              addr_ok;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pxi.pxi_wr};
        end
    end

    assign wr_s = sync_q[SYNC_STAGES-1];

`ifdef PXI_WR_FILTER_EN
    localparam int FCNT_W = $clog2(FILT_CYC + 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FILT_CYC - 1);

    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_q;

    // down-counter restarts whenever wr_s agrees with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= 1'b0;
            filt_cnt <= FCNT_LOAD;
        end else if (wr_s == filt_q) begin
            filt_cnt <= FCNT_LOAD;
        end else if (filt_cnt == '0) begin
            filt_q   <= wr_s;
            filt_cnt <= FCNT_LOAD;
        end else begin
            filt_cnt <= filt_cnt - 1'b1;
        end
    end

    assign wr_f = filt_q;
`else
    assign wr_f = wr_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        commit_en = 1'b0;
        upd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_f) begin
                    cap_en    = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                commit_en = 1'b1;
                state_nxt = COMMIT;
            end
            COMMIT: begin
                upd_en    = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!wr_f) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // extra MSB keeps the compare correct when NUM_REGS == 2**ADDR_W
    assign addr_ok = ({1'b0, addr_r} < (ADDR_W+1)'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            data_r   <= '0;
            wr_cnt   <= '0;
            err_addr <= 1'b0;
            reg_upd  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            if (cap_en) begin
                addr_r <= pxi.pxi_addr;
                data_r <= pxi.pxi_data;
            end

            if (commit_en && addr_ok) begin
                wr_cnt <= wr_cnt + 16'd1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_r == ADDR_W'(i)) begin
                        regs[i] <= data_r;
                    end
                end
            end

            // a new error wins over a simultaneous clear
            if (commit_en && !addr_ok) begin
                err_addr <= 1'b1;
            end else if (err_clr) begin
                err_addr <= 1'b0;
            end

            for (int i = 0; i < NUM_REGS; i++) begin
                reg_upd[i] <= upd_en && addr_ok && (addr_r == ADDR_W'(i));
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pxi_wr_regbank.sv
// Directed bench for pxi_wr_regbank: reset, valid/invalid writes, boundary address,
// long strobe and back-to-back writes, reset mid-write, and the strobe filter when PXI_WR_FILTER_EN is set.
module tb_pxi_wr_regbank;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 4;
    localparam int NUM_REGS    = 12;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 3;
    localparam int QW          = NUM_REGS * DATA_W;
`ifdef PXI_WR_FILTER_EN
    localparam int LAT = SYNC_STAGES + FILT_CYC + 2;
    localparam int GAP = FILT_CYC + 2;
`else
    localparam int LAT = SYNC_STAGES + 2;
    localparam int GAP = 2;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                err_clr = 1'b0;
    logic [QW-1:0]       reg_q;
    logic [NUM_REGS-1:0] reg_upd;
    logic                busy;
    logic                err_addr;
    logic [15:0]         wr_cnt;

    pxi_wr_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pxi ();

    pxi_wr_regbank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .RST_VAL('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pxi(pxi), .err_clr(err_clr),
        .reg_q(reg_q), .reg_upd(reg_upd), .busy(busy),
        .err_addr(err_addr), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int                  vectors = 0;
    int                  miscompares = 0;
    int                  upd_cnt;
    int                  upd0_cnt;
    logic [NUM_REGS-1:0] upd_or;
    logic                busy_seen;
    logic [QW-1:0]       exp_q;

    function automatic logic [DATA_W-1:0] reg_at(input int n);
        return reg_q[n*DATA_W +: DATA_W];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            upd_or    = upd_or | reg_upd;
            busy_seen = busy_seen | busy;
            if (reg_upd != '0) upd_cnt++;
            if (reg_upd[0]) upd0_cnt++;
        end
    endtask

    task automatic clr_mon();
        upd_or    = '0;
        upd_cnt   = 0;
        upd0_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic w);
        pxi.pxi_addr = a;
        pxi.pxi_data = d;
        pxi.pxi_wr   = w;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        pxi.pxi_wr = 1'b0;
        step(5);
        rst_n = 1'b1;
        step(1);
        exp_q = '0;
    endtask

    task automatic test_reset();
        drive('0, '0, 1'b0);
        clr_mon();
        apply_reset();
        vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL reset_reg_q: got %h want %h", reg_q, exp_q); end
        vectors++; if (wr_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_wr_cnt: got %h want 0000", wr_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (err_addr !== 1'b0) begin miscompares++; $display("FAIL reset_err_addr: got %b want 0", err_addr); end
        vectors++; if (reg_upd !== '0) begin miscompares++; $display("FAIL reset_reg_upd: got %h want 000", reg_upd); end
    endtask

    task automatic test_valid_write();
        clr_mon();
        drive(4'd3, 16'hA55A, 1'b1);
        step(LAT - 1);
        vectors++; if (reg_at(3) !== 16'h0000) begin miscompares++; $display("FAIL valid_early: reg3 got %h want 0000", reg_at(3)); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL valid_busy: got %b want 1", busy); end
        step(1);
        vectors++; if (reg_at(3) !== 16'hA55A) begin miscompares++; $display("FAIL valid_latency: reg3 got %h want a55a", reg_at(3)); end
        vectors++; if (reg_upd !== 12'h000) begin miscompares++; $display("FAIL valid_upd_early: got %h want 000", reg_upd); end
        step(1);
        vectors++; if (reg_upd !== 12'h008) begin miscompares++; $display("FAIL valid_upd: got %h want 008", reg_upd); end
        vectors++; if (wr_cnt !== 16'd1) begin miscompares++; $display("FAIL valid_wr_cnt: got %h want 0001", wr_cnt); end
        step(1);
        vectors++; if (reg_upd !== 12'h000) begin miscompares++; $display("FAIL valid_upd_width: got %h want 000", reg_upd); end
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        exp_q[3*DATA_W +: DATA_W] = 16'hA55A;
        vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL valid_others: got %h want %h", reg_q, exp_q); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL valid_idle: busy got %b want 0", busy); end
        vectors++; if (upd_cnt !== 1) begin miscompares++; $display("FAIL valid_upd_count: got %0d want 1", upd_cnt); end
    endtask

    task automatic test_invalid_addr();
        clr_mon();
        drive(4'd13, 16'h1234, 1'b1);
        step(6);
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        vectors++; if (err_addr !== 1'b1) begin miscompares++; $display("FAIL inv_err: got %b want 1", err_addr); end
        vectors++; if (upd_or !== '0) begin miscompares++; $display("FAIL inv_no_upd: got %h want 000", upd_or); end
        vectors++; if (wr_cnt !== 16'd1) begin miscompares++; $display("FAIL inv_wr_cnt: got %h want 0001", wr_cnt); end
        vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL inv_regs: got %h want %h", reg_q, exp_q); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        vectors++; if (err_addr !== 1'b0) begin miscompares++; $display("FAIL inv_err_clr: got %b want 0", err_addr); end
        // clear held across the commit edge of a second invalid write
        drive(4'd13, 16'h1234, 1'b1);
        step(LAT - 1);
        vectors++; if (err_addr !== 1'b0) begin miscompares++; $display("FAIL inv_err_pre: got %b want 0", err_addr); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        vectors++; if (err_addr !== 1'b1) begin miscompares++; $display("FAIL inv_set_wins: got %b want 1", err_addr); end
        step(2);
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        vectors++; if (err_addr !== 1'b1) begin miscompares++; $display("FAIL inv_sticky: got %b want 1", err_addr); end
    endtask

    task automatic test_boundary();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        clr_mon();
        drive(4'd11, 16'hBEEF, 1'b1);
        step(LAT);
        vectors++; if (reg_at(11) !== 16'hBEEF) begin miscompares++; $display("FAIL bnd_reg11: got %h want beef", reg_at(11)); end
        step(1);
        vectors++; if (reg_upd !== 12'h800) begin miscompares++; $display("FAIL bnd_upd11: got %h want 800", reg_upd); end
        step(1);
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        vectors++; if (err_addr !== 1'b0) begin miscompares++; $display("FAIL bnd_no_err: got %b want 0", err_addr); end
        clr_mon();
        drive(4'd12, 16'h5555, 1'b1);
        step(LAT + 2);
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        exp_q[11*DATA_W +: DATA_W] = 16'hBEEF;
        vectors++; if (err_addr !== 1'b1) begin miscompares++; $display("FAIL bnd_err12: got %b want 1", err_addr); end
        vectors++; if (upd_or !== '0) begin miscompares++; $display("FAIL bnd_no_upd12: got %h want 000", upd_or); end
        vectors++; if (wr_cnt !== 16'd2) begin miscompares++; $display("FAIL bnd_wr_cnt: got %h want 0002", wr_cnt); end
        vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL bnd_regs: got %h want %h", reg_q, exp_q); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clr_mon();
        drive(4'd0, 16'h0001, 1'b1);
        step(40);
        vectors++; if (upd0_cnt !== 1) begin miscompares++; $display("FAIL b2b_long_one: upd0 pulses got %0d want 1", upd0_cnt); end
        vectors++; if (reg_at(0) !== 16'h0001) begin miscompares++; $display("FAIL b2b_first: reg0 got %h want 0001", reg_at(0)); end
        pxi.pxi_wr = 1'b0;
        step(GAP);
        drive(4'd0, 16'h0002, 1'b1);
        step(LAT + 2);
        pxi.pxi_wr = 1'b0;
        step(LAT + 2);
        vectors++; if (upd0_cnt !== 2) begin miscompares++; $display("FAIL b2b_pulses: upd0 pulses got %0d want 2", upd0_cnt); end
        vectors++; if (upd_cnt !== 2) begin miscompares++; $display("FAIL b2b_all_pulses: got %0d want 2", upd_cnt); end
        vectors++; if (reg_at(0) !== 16'h0002) begin miscompares++; $display("FAIL b2b_last_wins: reg0 got %h want 0002", reg_at(0)); end
        vectors++; if (wr_cnt !== 16'd2) begin miscompares++; $display("FAIL b2b_wr_cnt: got %h want 0002", wr_cnt); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        clr_mon();
        drive(4'd5, 16'hFFFF, 1'b1);
        step(LAT - 1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_in_capt: busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_async: busy got %b want 0", busy); end
        pxi.pxi_wr = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(LAT + 3);
        vectors++; if (reg_at(5) !== 16'h0000) begin miscompares++; $display("FAIL mid_reg5: got %h want 0000", reg_at(5)); end
        vectors++; if (upd_or !== '0) begin miscompares++; $display("FAIL mid_no_upd: got %h want 000", upd_or); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_idle: busy got %b want 0", busy); end
        vectors++; if (wr_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_wr_cnt: got %h want 0000", wr_cnt); end
    endtask

`ifdef PXI_WR_FILTER_EN
    task automatic test_filter();
        apply_reset();
        clr_mon();
        drive(4'd1, 16'h00FF, 1'b1);
        step(2);
        pxi.pxi_wr = 1'b0;
        step(10);
        vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL filt_glitch_busy: got %b want 0", busy_seen); end
        vectors++; if (reg_at(1) !== 16'h0000) begin miscompares++; $display("FAIL filt_glitch_reg1: got %h want 0000", reg_at(1)); end
        pxi.pxi_wr = 1'b1;
        step(6);
        pxi.pxi_wr = 1'b0;
        vectors++; if (reg_at(1) !== 16'h0000) begin miscompares++; $display("FAIL filt_early: reg1 got %h want 0000", reg_at(1)); end
        step(1);
        vectors++; if (reg_at(1) !== 16'h00FF) begin miscompares++; $display("FAIL filt_latency: reg1 got %h want 00ff", reg_at(1)); end
        step(LAT + 3);
        vectors++; if (upd_cnt !== 1) begin miscompares++; $display("FAIL filt_upd_count: got %0d want 1", upd_cnt); end
        vectors++; if (wr_cnt !== 16'd1) begin miscompares++; $display("FAIL filt_wr_cnt: got %h want 0001", wr_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_valid_write();
        test_invalid_addr();
        test_boundary();
        test_back_to_back();
        test_reset_mid_write();
`ifdef PXI_WR_FILTER_EN
        test_filter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
